// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_unit
// Description : Fetch program counter with branch/jump redirect, link-register
//               write strobe and optional MIPS-style delay slot.
//               Optional feature macro: DELAY_SLOT_EN (delay-slot semantics).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] br_pc,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  input  logic [31:0] jmp_pc,
  input  logic        link_req,
  output logic [31:0] pc,
  output logic        if_id_flush,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic        slot_err
);

  localparam logic [31:0] C_PC_STEP     = 32'd4;
  localparam logic [31:0] C_LINK_OFFSET = 32'd8;
  localparam logic [31:0] C_ALIGN_MASK  = 32'hFFFF_FFFC;

  logic [31:0] r_pc;
  logic        r_link_we;
  logic [31:0] r_link_addr;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_src_pc;
  logic [31:0] w_pc_inc;
  logic [31:0] w_pc_nxt;
  logic        w_accept;

  // Redirect request decode: the branch (older, EX stage) wins over the jump.
  always_comb begin
    w_redirect = br_taken | jmp_valid;
    w_target   = (br_taken ? br_target : jmp_target) & C_ALIGN_MASK;
    w_src_pc   = br_taken ? br_pc : jmp_pc;
    w_pc_inc   = r_pc + C_PC_STEP;
  end

`ifdef DELAY_SLOT_EN
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_SLOT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_saved_target;
  logic [31:0] w_saved_nxt;
  logic        r_slot_err;
  logic        w_slot_err_nxt;

  // State, saved target and sticky slot error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_RUN;
      r_saved_target <= 32'h0;
      r_slot_err     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_saved_target <= w_saved_nxt;
      r_slot_err     <= w_slot_err_nxt;
    end
  end

  // Next-state logic: a redirect first executes the slot instruction, then jumps.
  always_comb begin
    w_state_nxt    = r_state;
    w_saved_nxt    = r_saved_target;
    w_slot_err_nxt = r_slot_err;
    w_pc_nxt       = r_pc;
    w_accept       = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_redirect) begin
          w_accept    = 1'b1;
          w_saved_nxt = w_target;
          w_state_nxt = ST_SLOT;
        end
        if (!stall) begin
          w_pc_nxt = w_pc_inc;
        end
      end
      ST_SLOT: begin
        // A second redirect inside the slot is illegal: ignore it, flag it.
        if (w_redirect) begin
          w_slot_err_nxt = 1'b1;
        end
        if (!stall) begin
          w_pc_nxt    = r_saved_target;
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign if_id_flush = 1'b0;
  assign slot_err    = r_slot_err;
`else
  // Without a delay slot there is a single RUN state: redirect immediately and
  // squash the wrong-path instruction already fetched.
  always_comb begin
    w_accept = w_redirect;
    if (w_redirect) begin
      w_pc_nxt = w_target;
    end else if (stall) begin
      w_pc_nxt = r_pc;
    end else begin
      w_pc_nxt = w_pc_inc;
    end
  end

  assign if_id_flush = w_redirect & rst_n;
  assign slot_err    = 1'b0;
`endif

  // Fetch PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= 32'h0;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  // Link write strobe for one cycle after an accepted linking redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_link_we   <= 1'b0;
      r_link_addr <= 32'h0;
    end else begin
      r_link_we <= w_accept & link_req;
      if (w_accept && link_req) begin
        r_link_addr <= w_src_pc + C_LINK_OFFSET;
      end
    end
  end

  assign pc        = r_pc;
  assign link_we   = r_link_we;
  assign link_addr = r_link_addr;

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_redirect_unit
// Description : Directed self-checking bench for pc_redirect_unit; expected
//               values are queued when stimulus is driven and compared when
//               the DUT output becomes observable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_redirect_unit;

  localparam int C_SEL_PC    = 0;
  localparam int C_SEL_FLUSH = 1;
  localparam int C_SEL_LWE   = 2;
  localparam int C_SEL_LADDR = 3;
  localparam int C_SEL_SERR  = 4;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] br_pc;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic [31:0] jmp_pc;
  logic        link_req;
  logic [31:0] pc;
  logic        if_id_flush;
  logic        link_we;
  logic [31:0] link_addr;
  logic        slot_err;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  pc_redirect_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .br_pc      (br_pc),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .jmp_pc     (jmp_pc),
    .link_req   (link_req),
    .pc         (pc),
    .if_id_flush(if_id_flush),
    .link_we    (link_we),
    .link_addr  (link_addr),
    .slot_err   (slot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      C_SEL_PC:    return pc;
      C_SEL_FLUSH: return {31'h0, if_id_flush};
      C_SEL_LWE:   return {31'h0, link_we};
      C_SEL_LADDR: return link_addr;
      default:     return {31'h0, slot_err};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_chk++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic drive(input logic st, input logic bt, input logic [31:0] bta,
                       input logic [31:0] bpc, input logic jv, input logic [31:0] jta,
                       input logic [31:0] jpc, input logic lr);
    stall      = st;
    br_taken   = bt;
    br_target  = bta;
    br_pc      = bpc;
    jmp_valid  = jv;
    jmp_target = jta;
    jmp_pc     = jpc;
    link_req   = lr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Directed sequence.
  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push("rst_pc", C_SEL_PC, 32'h0);
    push("rst_flush", C_SEL_FLUSH, 32'h0);
    push("rst_link_we", C_SEL_LWE, 32'h0);
    push("rst_link_addr", C_SEL_LADDR, 32'h0);
    push("rst_slot_err", C_SEL_SERR, 32'h0);
    drain();
    rst_n = 1'b1;

    // Sequential fetch 0,4,8,C,10.
    for (int i = 1; i <= 4; i++) begin
      push("seq_pc", C_SEL_PC, 32'(i * 4));
      tick();
    end

`ifndef DELAY_SLOT_EN
    // Taken branch with link at pc=10.
    drive(1'b0, 1'b1, 32'h40, 32'h8, 1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    push("br_flush", C_SEL_FLUSH, 32'h1);
    drain();
    push("br_pc", C_SEL_PC, 32'h40);
    push("br_link_we", C_SEL_LWE, 32'h1);
    push("br_link_addr", C_SEL_LADDR, 32'h10);
    tick();
    idle();
    #1;
    push("idle_flush", C_SEL_FLUSH, 32'h0);
    drain();
    push("post_br_pc", C_SEL_PC, 32'h44);
    push("post_br_link_we", C_SEL_LWE, 32'h0);
    push("post_br_link_hold", C_SEL_LADDR, 32'h10);
    tick();

    // Stall holds the PC.
    stall = 1'b1;
    push("stall_pc_a", C_SEL_PC, 32'h44);
    tick();
    push("stall_pc_b", C_SEL_PC, 32'h44);
    tick();

    // Branch and jump together under stall: branch wins, jump dropped.
    drive(1'b1, 1'b1, 32'h200, 32'h80, 1'b1, 32'h300, 32'h90, 1'b1);
    #1;
    push("prio_flush", C_SEL_FLUSH, 32'h1);
    drain();
    push("prio_pc", C_SEL_PC, 32'h200);
    push("prio_link_we", C_SEL_LWE, 32'h1);
    push("prio_link_addr", C_SEL_LADDR, 32'h88);
    tick();

    // Jump with unaligned target and no link.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h103, 32'h200, 1'b0);
    push("jmp_pc", C_SEL_PC, 32'h100);
    push("jmp_nolink_we", C_SEL_LWE, 32'h0);
    push("jmp_nolink_addr", C_SEL_LADDR, 32'h88);
    tick();

    // Wrap-around from FFFF_FFFC.
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
    push("top_pc", C_SEL_PC, 32'hFFFF_FFFC);
    tick();
    idle();
    push("wrap_pc", C_SEL_PC, 32'h0);
    tick();
    push("wrap_next_pc", C_SEL_PC, 32'h4);
    tick();

    // Reset asserted mid-redirect.
    drive(1'b0, 1'b1, 32'h700, 32'h4, 1'b0, 32'h0, 32'h0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    push("mid_rst_pc", C_SEL_PC, 32'h0);
    push("mid_rst_flush", C_SEL_FLUSH, 32'h0);
    push("mid_rst_link_we", C_SEL_LWE, 32'h0);
    push("mid_rst_link_addr", C_SEL_LADDR, 32'h0);
    push("mid_rst_slot_err", C_SEL_SERR, 32'h0);
    drain();
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    push("after_rst_pc0", C_SEL_PC, 32'h0);
    drain();
    push("after_rst_pc1", C_SEL_PC, 32'h4);
    tick();
`else
    // Jump with delay slot at pc=10.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h103, 32'h10, 1'b1);
    #1;
    push("ds_jmp_flush", C_SEL_FLUSH, 32'h0);
    drain();
    push("ds_slot_pc", C_SEL_PC, 32'h14);
    push("ds_link_we", C_SEL_LWE, 32'h1);
    push("ds_link_addr", C_SEL_LADDR, 32'h18);
    tick();
    idle();
    #1;
    push("ds_slot_flush", C_SEL_FLUSH, 32'h0);
    drain();
    push("ds_target_pc", C_SEL_PC, 32'h100);
    push("ds_link_we_off", C_SEL_LWE, 32'h0);
    tick();
    push("ds_run_pc", C_SEL_PC, 32'h104);
    tick();

    // Branch and jump together under stall: branch wins.
    drive(1'b1, 1'b1, 32'h200, 32'h100, 1'b1, 32'h300, 32'h104, 1'b1);
    #1;
    push("ds_prio_flush", C_SEL_FLUSH, 32'h0);
    drain();
    push("ds_prio_hold_pc", C_SEL_PC, 32'h104);
    push("ds_prio_link_we", C_SEL_LWE, 32'h1);
    push("ds_prio_link_addr", C_SEL_LADDR, 32'h108);
    tick();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    push("ds_slot_stall_pc", C_SEL_PC, 32'h104);
    tick();
    idle();
    push("ds_prio_pc", C_SEL_PC, 32'h200);
    tick();

    // Redirect inside the slot is ignored and flagged.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h500, 32'h200, 1'b0);
    push("ds_err_slot_pc", C_SEL_PC, 32'h204);
    tick();
    drive(1'b0, 1'b1, 32'h600, 32'h204, 1'b0, 32'h0, 32'h0, 1'b1);
    push("ds_err_pc", C_SEL_PC, 32'h500);
    push("ds_err_flag", C_SEL_SERR, 32'h1);
    push("ds_err_link_we", C_SEL_LWE, 32'h0);
    tick();
    idle();
    push("ds_err_next_pc", C_SEL_PC, 32'h504);
    push("ds_err_sticky", C_SEL_SERR, 32'h1);
    tick();

    // Wrap-around from FFFF_FFFC.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h504, 1'b0);
    push("ds_wrap_slot_pc", C_SEL_PC, 32'h508);
    tick();
    idle();
    push("ds_top_pc", C_SEL_PC, 32'hFFFF_FFFC);
    tick();
    push("ds_wrap_pc", C_SEL_PC, 32'h0);
    tick();

    // Reset while in the slot discards the saved target.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h900, 32'h0, 1'b0);
    push("ds_rst_slot_pc", C_SEL_PC, 32'h4);
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    push("ds_rst_pc", C_SEL_PC, 32'h0);
    push("ds_rst_slot_err", C_SEL_SERR, 32'h0);
    push("ds_rst_link_we", C_SEL_LWE, 32'h0);
    push("ds_rst_link_addr", C_SEL_LADDR, 32'h0);
    push("ds_rst_flush", C_SEL_FLUSH, 32'h0);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push("ds_after_rst_pc0", C_SEL_PC, 32'h0);
    drain();
    push("ds_after_rst_pc1", C_SEL_PC, 32'h4);
    tick();
    push("ds_after_rst_pc2", C_SEL_PC, 32'h8);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL: stall  in  1  hazard stall; hold fetch PC.
REQ-004 SHALL: br_taken  in  1  branch-taken from condition handler (EX stage).
REQ-005 SHALL: br_target  in  32  branch target address.
REQ-006 SHALL: br_pc  in  32  address of resolving branch.
REQ-007 SHALL: jmp_valid  in  1  jump decoded (ID stage).
REQ-008 SHALL: jmp_target  in  32  jump target address.
REQ-009 SHALL: jmp_pc  in  32  address of the jump.
REQ-010 SHALL: link_req  in  1  the redirecting branch or jump writes a link register.
REQ-011 SHALL: pc  out  32  fetch address.
REQ-012 SHALL: if_id_flush  out  1  squash IF/ID contents this cycle.
REQ-013 SHALL: link_we  out  1  one-cycle link write strobe.
REQ-014 SHALL: link_addr  out  32  link value.
REQ-015 SHALL: slot_err  out  1  sticky flag for a redirect requested during a pending delay slot.

Function
REQ-016 SHALL: redirect = br_taken | jmp_valid; br_taken has priority; a simultaneous jump is dropped.
REQ-017 SHALL: the selected target is br_target or jmp_target with bits [1:0] forced to 0.
REQ-018 SHALL: FSM states are RUN and SLOT; SLOT exists only with DELAY_SLOT_EN.
REQ-019 SHALL: in RUN with no redirect and no stall, pc <= pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-020 SHALL: in RUN with stall and no redirect, pc holds.
REQ-021 SHALL: a redirect is accepted even while stall=1; stall never blocks a redirect.
REQ-022 SHALL: on an accepted redirect, link_we=1 and link_addr = (source pc)+8 on the next cycle when link_req=1; link_we is otherwise 0 and link_addr holds.
REQ-023 SHALL: if_id_flush is combinational and is 0 whenever no redirect is accepted in RUN.

Reset
REQ-024 SHALL: while rst_n=0, immediately: pc=32'h0, state=RUN, if_id_flush=0, link_we=0, link_addr=0, slot_err=0, saved target=0.
REQ-025 SHALL: reset mid-redirect or in SLOT discards the saved target; the first fetch after reset is 0.

Configuration
REQ-026 SHALL: macro DELAY_SLOT_EN selects MIPS delay-slot semantics.
REQ-027 SHALL: without DELAY_SLOT_EN, an accepted redirect sets pc <= target at the next edge and asserts if_id_flush for that same cycle.
REQ-028 SHALL: with DELAY_SLOT_EN, an accepted redirect stores the target and enters SLOT; pc <= pc+4 if stall=0, else pc holds; if_id_flush stays 0.
REQ-029 SHALL: in SLOT with stall=0, pc <= saved target and the FSM returns to RUN; with stall=1, SLOT and pc hold.
REQ-030 SHALL: in SLOT, any redirect is ignored and sets slot_err=1 until reset.
REQ-031 SHALL: with DELAY_SLOT_EN, link_addr = source pc+8; the link write occurs on acceptance, not on SLOT exit.

Verification
REQ-032 SHALL: reset release, no stimulus, 4 cycles -> pc sequence 0,4,8,C,10.
REQ-033 SHALL: without DELAY_SLOT_EN: at pc=10, br_taken=1, br_target=40, link_req=1, br_pc=8 -> if_id_flush=1 that cycle; next pc=40, link_we=1, link_addr=10.
REQ-034 SHALL: with DELAY_SLOT_EN: at pc=10, jmp_valid=1, jmp_target=103 -> pc 14, then 100; if_id_flush never 1.
REQ-035 SHALL: same cycle br_taken=1 (target 200) and jmp_valid=1 (target 300), stall=1 -> next pc=200; the jump is dropped.
REQ-036 SHALL: with DELAY_SLOT_EN: redirect while in SLOT -> slot_err=1; the original target is still taken; rst_n low then clears slot_err and sets pc=0.
REQ-037 SHALL: pc=FFFF_FFFC, no redirect -> next pc=0.
